spatz_offload_issuer: RTL and testbench

//   Core-side issuer for the vector-accelerator offload interface. Accepts

---
 rtl/spatz_offload_issuer.sv | 217 +++++++++++++++++++++
 tb/tb_spatz_offload_issuer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_offload_issuer.sv
// Core-side issuer for the vector-accelerator offload interface.
// Screens opcodes, queues legal instructions, merges responses.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   core_req_*            instruction + operands from the core (valid/ready)
//   acc_req_*             FIFO head towards the accelerator (valid/ready)
//   acc_rsp_*             accelerator results (valid/ready)
//   core_rsp_*            writeback to the core, error flag for illegal instrs
//   outstanding_o         response-expecting instrs reserved, not yet answered
//   busy_o                FIFO non-empty or reservations pending
module spatz_offload_issuer #(
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned NumOutstanding = 8,
  parameter int unsigned IdWidth        = 5
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                core_req_valid_i,
  output logic                                core_req_ready_o,
  input  logic [31:0]                         core_req_instr_i,
  input  logic [31:0]                         core_req_rs1_i,
  input  logic [31:0]                         core_req_rs2_i,
  input  logic [IdWidth-1:0]                  core_req_id_i,
  output logic                                acc_req_valid_o,
  input  logic                                acc_req_ready_i,
  output logic [31:0]                         acc_req_instr_o,
  output logic [31:0]                         acc_req_rs1_o,
  output logic [31:0]                         acc_req_rs2_o,
  output logic [IdWidth-1:0]                  acc_req_id_o,
  input  logic                                acc_rsp_valid_i,
  output logic                                acc_rsp_ready_o,
  input  logic [IdWidth-1:0]                  acc_rsp_id_i,
  input  logic [31:0]                         acc_rsp_data_i,
  output logic                                core_rsp_valid_o,
  input  logic                                core_rsp_ready_i,
  output logic [IdWidth-1:0]                  core_rsp_id_o,
  output logic [31:0]                         core_rsp_data_o,
  output logic                                core_rsp_error_o,
  output logic [$clog2(NumOutstanding+1)-1:0] outstanding_o,
  output logic                                busy_o
);

  localparam int unsigned OutW = $clog2(NumOutstanding + 1);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  localparam logic [6:0] OpVec     = 7'b1010111;
  localparam logic [6:0] OpLoadFp  = 7'b0000111;
  localparam logic [6:0] OpStoreFp = 7'b0100111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  localparam logic [OutW-1:0] MaxOut  = OutW'(NumOutstanding);
  localparam logic [CntW-1:0] FifoMax = CntW'(FifoDepth);

  // ---------------- opcode screening ----------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       legal;
  logic       rsp_exp;

  assign opcode = core_req_instr_i[6:0];
  assign funct3 = core_req_instr_i[14:12];

  always_comb begin
    legal   = 1'b0;
    rsp_exp = 1'b0;
    case (opcode)
      OpVec: begin
        legal   = 1'b1;
        rsp_exp = (funct3 == 3'b111);
      end
      OpLoadFp:  legal = 1'b1;
      OpStoreFp: legal = 1'b1;
      OpSystem: begin
        // funct3==0 is ecall/ebreak/xret: not for the accelerator
        legal   = (funct3 != 3'b000);
        rsp_exp = (funct3 != 3'b000);
      end
      default: begin
        legal   = 1'b0;
        rsp_exp = 1'b0;
      end
    endcase
  end

  // ---------------- state ----------------
  logic [31:0]        instr_q [FifoDepth];
  logic [31:0]        rs1_q   [FifoDepth];
  logic [31:0]        rs2_q   [FifoDepth];
  logic [IdWidth-1:0] id_q    [FifoDepth];
  logic [PtrW-1:0]    wptr_q, wptr_d;
  logic [PtrW-1:0]    rptr_q, rptr_d;
  logic [CntW-1:0]    fcnt_q, fcnt_d;
  logic [OutW-1:0]    cnt_q, cnt_d;
  logic               err_valid_q, err_valid_d;
  logic [IdWidth-1:0] err_id_q, err_id_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic err_load;
  logic err_clr;
  logic inc;
  logic dec;

  assign full  = (fcnt_q == FifoMax);
  assign empty = (fcnt_q == '0);

  // ---------------- request side ----------------
  always_comb begin
    if (legal) begin
      core_req_ready_o = !full && (!rsp_exp || (cnt_q < MaxOut));
    end else begin
      core_req_ready_o = !err_valid_q;
    end
  end

  assign push     = core_req_valid_i && core_req_ready_o && legal;
  assign err_load = core_req_valid_i && core_req_ready_o && !legal;
  assign inc      = push && rsp_exp;

  assign acc_req_valid_o = !empty;
  assign acc_req_instr_o = instr_q[rptr_q];
  assign acc_req_rs1_o   = rs1_q[rptr_q];
  assign acc_req_rs2_o   = rs2_q[rptr_q];
  assign acc_req_id_o    = id_q[rptr_q];
  assign pop             = acc_req_valid_o && acc_req_ready_i;

  // ---------------- response side ----------------
  assign acc_rsp_ready_o  = core_rsp_ready_i && !err_valid_q;
  assign core_rsp_valid_o = err_valid_q || acc_rsp_valid_i;
  assign core_rsp_error_o = err_valid_q;
  assign core_rsp_id_o    = err_valid_q ? err_id_q : acc_rsp_id_i;
  assign core_rsp_data_o  = err_valid_q ? 32'h0 : acc_rsp_data_i;

  assign err_clr = err_valid_q && core_rsp_ready_i;
  assign dec     = acc_rsp_valid_i && acc_rsp_ready_o;

  assign outstanding_o = cnt_q;
  assign busy_o        = !empty || (cnt_q != '0);

  // ---------------- next state ----------------
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    fcnt_d      = fcnt_q;
    cnt_d       = cnt_q;
    err_valid_d = err_valid_q;
    err_id_d    = err_id_q;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop) fcnt_d = fcnt_q + 1'b1;
    if (pop && !push) fcnt_d = fcnt_q - 1'b1;

    // a stray response at zero must not wrap the counter
    if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (err_load) begin
      err_valid_d = 1'b1;
      err_id_d    = core_req_id_i;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      cnt_q       <= '0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
      cnt_q       <= cnt_d;
      err_valid_q <= err_valid_d;
      err_id_q    <= err_id_d;
    end
  end

  // storage is reset so the head reads zero while empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FifoDepth; i++) begin
        instr_q[i] <= '0;
        rs1_q[i]   <= '0;
        rs2_q[i]   <= '0;
        id_q[i]    <= '0;
      end
    end else if (push) begin
      instr_q[wptr_q] <= core_req_instr_i;
      rs1_q[wptr_q]   <= core_req_rs1_i;
      rs2_q[wptr_q]   <= core_req_rs2_i;
      id_q[wptr_q]    <= core_req_id_i;
    end
  end

`ifndef SYNTHESIS
  // accelerator must not answer with nothing reserved
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(acc_rsp_valid_i && (cnt_q == '0)));
    end
  end
`endif

endmodule

// File: tb/tb_spatz_offload_issuer.sv
// Scoreboard bench for spatz_offload_issuer.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_spatz_offload_issuer;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  id;
  } req_t;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  localparam logic [31:0] VSETVLI = 32'h0d0070d7;
  localparam logic [31:0] ILL_OP  = 32'h00000033;
  localparam logic [31:0] ECALL   = 32'h00000073;
  localparam logic [31:0] FLW     = 32'h00002007;
  localparam logic [31:0] FSW     = 32'h00002027;

  logic        clk;
  logic        rst_i;
  logic        core_req_valid_i;
  logic        core_req_ready_o;
  logic [31:0] core_req_instr_i;
  logic [31:0] core_req_rs1_i;
  logic [31:0] core_req_rs2_i;
  logic [4:0]  core_req_id_i;
  logic        acc_req_valid_o;
  logic        acc_req_ready_i;
  logic [31:0] acc_req_instr_o;
  logic [31:0] acc_req_rs1_o;
  logic [31:0] acc_req_rs2_o;
  logic [4:0]  acc_req_id_o;
  logic        acc_rsp_valid_i;
  logic        acc_rsp_ready_o;
  logic [4:0]  acc_rsp_id_i;
  logic [31:0] acc_rsp_data_i;
  logic        core_rsp_valid_o;
  logic        core_rsp_ready_i;
  logic [4:0]  core_rsp_id_o;
  logic [31:0] core_rsp_data_o;
  logic        core_rsp_error_o;
  logic [3:0]  outstanding_o;
  logic        busy_o;

  int checks;
  int errors;

  req_t req_q[$];
  rsp_t rsp_q[$];

  spatz_offload_issuer dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .core_req_valid_i (core_req_valid_i),
    .core_req_ready_o (core_req_ready_o),
    .core_req_instr_i (core_req_instr_i),
    .core_req_rs1_i   (core_req_rs1_i),
    .core_req_rs2_i   (core_req_rs2_i),
    .core_req_id_i    (core_req_id_i),
    .acc_req_valid_o  (acc_req_valid_o),
    .acc_req_ready_i  (acc_req_ready_i),
    .acc_req_instr_o  (acc_req_instr_o),
    .acc_req_rs1_o    (acc_req_rs1_o),
    .acc_req_rs2_o    (acc_req_rs2_o),
    .acc_req_id_o     (acc_req_id_o),
    .acc_rsp_valid_i  (acc_rsp_valid_i),
    .acc_rsp_ready_o  (acc_rsp_ready_o),
    .acc_rsp_id_i     (acc_rsp_id_i),
    .acc_rsp_data_i   (acc_rsp_data_i),
    .core_rsp_valid_o (core_rsp_valid_o),
    .core_rsp_ready_i (core_rsp_ready_i),
    .core_rsp_id_o    (core_rsp_id_o),
    .core_rsp_data_o  (core_rsp_data_o),
    .core_rsp_error_o (core_rsp_error_o),
    .outstanding_o    (outstanding_o),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one core request for one cycle; expectation pushed up front.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] id,
                       input bit accept, input bit illegal);
    core_req_valid_i = 1'b1;
    core_req_instr_i = ins;
    core_req_rs1_i   = a;
    core_req_rs2_i   = b;
    core_req_id_i    = id;
    if (accept) begin
      if (illegal) rsp_q.push_back('{id: id, data: 32'h0, err: 1'b1});
      else req_q.push_back('{instr: ins, rs1: a, rs2: b, id: id});
    end
    @(negedge clk);
    chk("core_req_ready", 64'(core_req_ready_o), 64'(accept));
    @(posedge clk);
    #1;
    core_req_valid_i = 1'b0;
  endtask

  task automatic acc_respond(input logic [4:0] id, input logic [31:0] d);
    acc_rsp_valid_i = 1'b1;
    acc_rsp_id_i    = id;
    acc_rsp_data_i  = d;
    rsp_q.push_back('{id: id, data: d, err: 1'b0});
    @(negedge clk);
    chk("acc_rsp_ready", 64'(acc_rsp_ready_o), 64'(1));
    @(posedge clk);
    #1;
    acc_rsp_valid_i = 1'b0;
  endtask

  // Monitor: compares every handshake against the scoreboard queues.
  initial begin
    req_t er;
    rsp_t es;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (acc_req_valid_o && acc_req_ready_i) begin
          if (req_q.size() == 0) begin
            chk("acc_req_unexpected", 64'(1), 64'(0));
          end else begin
            er = req_q.pop_front();
            chk("acc_req_instr", 64'(acc_req_instr_o), 64'(er.instr));
            chk("acc_req_rs1", 64'(acc_req_rs1_o), 64'(er.rs1));
            chk("acc_req_rs2", 64'(acc_req_rs2_o), 64'(er.rs2));
            chk("acc_req_id", 64'(acc_req_id_o), 64'(er.id));
          end
        end
        if (core_rsp_valid_o && core_rsp_ready_i) begin
          if (rsp_q.size() == 0) begin
            chk("core_rsp_unexpected", 64'(1), 64'(0));
          end else begin
            es = rsp_q.pop_front();
            chk("core_rsp_id", 64'(core_rsp_id_o), 64'(es.id));
            chk("core_rsp_data", 64'(core_rsp_data_o), 64'(es.data));
            chk("core_rsp_err", 64'(core_rsp_error_o), 64'(es.err));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] vec [4];
    checks = 0;
    errors = 0;
    vec[0] = 32'h020000d7;
    vec[1] = 32'h02000157;
    vec[2] = 32'h020001d7;
    vec[3] = 32'h02000257;
    rst_i            = 1'b1;
    core_req_valid_i = 1'b0;
    core_req_instr_i = '0;
    core_req_rs1_i   = '0;
    core_req_rs2_i   = '0;
    core_req_id_i    = '0;
    acc_req_ready_i  = 1'b0;
    acc_rsp_valid_i  = 1'b0;
    acc_rsp_id_i     = '0;
    acc_rsp_data_i   = '0;
    core_rsp_ready_i = 1'b1;
    #3;
    chk("rst_acc_valid", 64'(acc_req_valid_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_outstanding", 64'(outstanding_o), 64'(0));
    chk("rst_rsp_valid", 64'(core_rsp_valid_o), 64'(0));
    chk("rst_acc_instr", 64'(acc_req_instr_o), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // fill FIFO with accelerator stalled, 5th must stall
    issue(vec[0], 32'h100, 32'h200, 5'd1, 1, 0);
    chk("fifo_latency", 64'(acc_req_valid_o), 64'(1));
    for (int i = 1; i < 4; i++) begin
      issue(vec[i], 32'h100 + i, 32'h200 + i, 5'(i + 1), 1, 0);
    end
    issue(vec[0], 32'hdead, 32'hbeef, 5'd9, 0, 0);
    acc_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_valid", 64'(acc_req_valid_o), 64'(1));
    end
    @(negedge clk);
    chk("drain_empty", 64'(acc_req_valid_o), 64'(0));
    chk("drain_busy", 64'(busy_o), 64'(0));
    @(posedge clk);
    #1;

    // vsetvli round trip
    issue(VSETVLI, 32'h10, 32'h0, 5'd3, 1, 0);
    chk("vset_out1", 64'(outstanding_o), 64'(1));
    acc_respond(5'd3, 32'h40);
    chk("vset_out0", 64'(outstanding_o), 64'(0));

    // reservation limit
    for (int i = 0; i < 8; i++) begin
      issue(VSETVLI, 32'(i), 32'h0, 5'(10 + i), 1, 0);
    end
    chk("limit_out8", 64'(outstanding_o), 64'(8));
    core_req_valid_i = 1'b1;
    core_req_instr_i = VSETVLI;
    core_req_rs1_i   = 32'h99;
    core_req_rs2_i   = 32'h0;
    core_req_id_i    = 5'd18;
    @(negedge clk);
    chk("limit_stall", 64'(core_req_ready_o), 64'(0));
    @(posedge clk);
    #1;
    acc_rsp_valid_i = 1'b1;
    acc_rsp_id_i    = 5'd10;
    acc_rsp_data_i  = 32'h11;
    rsp_q.push_back('{id: 5'd10, data: 32'h11, err: 1'b0});
    @(negedge clk);
    chk("limit_stall2", 64'(core_req_ready_o), 64'(0));
    @(posedge clk);
    #1;
    acc_rsp_valid_i = 1'b0;
    req_q.push_back('{instr: VSETVLI, rs1: 32'h99, rs2: 32'h0, id: 5'd18});
    @(negedge clk);
    chk("limit_out7", 64'(outstanding_o), 64'(7));
    chk("limit_accept", 64'(core_req_ready_o), 64'(1));
    @(posedge clk);
    #1;
    core_req_valid_i = 1'b0;
    chk("limit_out8b", 64'(outstanding_o), 64'(8));
    for (int i = 11; i < 19; i++) acc_respond(5'(i), 32'(i * 3));
    chk("limit_out0", 64'(outstanding_o), 64'(0));

    // illegal instruction, second illegal stalls while pending
    core_rsp_ready_i = 1'b0;
    issue(ILL_OP, 32'h1, 32'h2, 5'd7, 1, 1);
    chk("ill_no_fwd", 64'(acc_req_valid_o), 64'(0));
    chk("ill_valid", 64'(core_rsp_valid_o), 64'(1));
    chk("ill_err", 64'(core_rsp_error_o), 64'(1));
    chk("ill_id", 64'(core_rsp_id_o), 64'(7));
    chk("ill_data", 64'(core_rsp_data_o), 64'(0));
    issue(ILL_OP, 32'h1, 32'h2, 5'd8, 0, 1);
    core_rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;

    // error has priority over a simultaneous accelerator response
    issue(VSETVLI, 32'h5, 32'h0, 5'd4, 1, 0);
    issue(ECALL, 32'h0, 32'h0, 5'd9, 1, 1);
    acc_rsp_valid_i = 1'b1;
    acc_rsp_id_i    = 5'd4;
    acc_rsp_data_i  = 32'h77;
    rsp_q.push_back('{id: 5'd4, data: 32'h77, err: 1'b0});
    @(negedge clk);
    chk("prio_blocked", 64'(acc_rsp_ready_o), 64'(0));
    @(negedge clk);
    chk("prio_pass", 64'(acc_rsp_ready_o), 64'(1));
    @(posedge clk);
    #1;
    acc_rsp_valid_i = 1'b0;
    chk("prio_out0", 64'(outstanding_o), 64'(0));

    // reset mid-operation
    acc_req_ready_i = 1'b0;
    issue(VSETVLI, 32'h1, 32'h0, 5'd20, 1, 0);
    issue(VSETVLI, 32'h2, 32'h0, 5'd21, 1, 0);
    issue(FLW, 32'h3, 32'h0, 5'd22, 1, 0);
    chk("pre_rst_out2", 64'(outstanding_o), 64'(2));
    chk("pre_rst_busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    #1;
    chk("mid_rst_acc_valid", 64'(acc_req_valid_o), 64'(0));
    chk("mid_rst_acc_instr", 64'(acc_req_instr_o), 64'(0));
    chk("mid_rst_out", 64'(outstanding_o), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_rsp", 64'(core_rsp_valid_o), 64'(0));
    req_q.delete();
    rsp_q.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // clean operation after reset
    acc_req_ready_i = 1'b1;
    issue(FSW, 32'h55, 32'h66, 5'd5, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("end_req_q", 64'(req_q.size()), 64'(0));
    chk("end_rsp_q", 64'(rsp_q.size()), 64'(0));
    chk("end_busy", 64'(busy_o), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
